// File: rtl/fpu_op_sequencer_if.sv
// Handshake bundle between the FPU operand sequencer and its byte streams / FPU multiplier.
// The master modport is the sequencer's view; the slave modport is the environment's view.
`timescale 1ns/1ps
interface fpu_op_sequencer_if;
  logic [7:0]  in_byte;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        fpu_start;
  logic        fpu_done;
  logic [31:0] fpu_result;
  logic [7:0]  out_byte;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        err;

  modport master (
    input  in_byte, in_valid, fpu_done, fpu_result, out_ready,
    output in_ready, op_a, op_b, fpu_start, out_byte, out_valid, busy, err
  );

  modport slave (
    output in_byte, in_valid, fpu_done, fpu_result, out_ready,
    input  in_ready, op_a, op_b, fpu_start, out_byte, out_valid, busy, err
  );
endinterface

// File: rtl/fpu_op_sequencer.sv
// Collects two little-endian 32-bit operands from a byte stream, launches the FPU and streams the result.
// Optional WAIT timeout (result forced to quiet NaN, sticky err) is enabled by defining FPU_SEQ_TIMEOUT_EN.
`timescale 1ns/1ps
module fpu_op_sequencer #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic                clk,
  input logic                rst_n,
  fpu_op_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_SEND  = 2'd3
  } state_t;

  state_t      state_r;
  logic [2:0]  byte_cnt_r;
  logic [1:0]  send_cnt_r;
  logic [31:0] op_a_r;
  logic [31:0] op_b_r;
  logic [31:0] result_r;
  logic [7:0]  out_byte_r;
  logic        fpu_start_r;
  logic        out_valid_r;
  logic        in_ready_r;
  logic        busy_r;
  logic        in_accept_s;
  logic        out_accept_s;

`ifdef FPU_SEQ_TIMEOUT_EN
  localparam int          WAIT_CNT_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] TIMEOUT_RESULT = 32'h7FC0_0000;
  logic [WAIT_CNT_W-1:0] wait_cnt_r;
  logic                  err_r;
  logic                  timeout_s;
  assign timeout_s = (wait_cnt_r == WAIT_LAST);
`endif

  function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  assign in_accept_s  = bus.in_valid && in_ready_r;
  assign out_accept_s = out_valid_r && bus.out_ready;

  // Sequencer FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_LOAD;
      byte_cnt_r  <= 3'd0;
      send_cnt_r  <= 2'd0;
      op_a_r      <= 32'h0000_0000;
      op_b_r      <= 32'h0000_0000;
      result_r    <= 32'h0000_0000;
      out_byte_r  <= 8'h00;
      fpu_start_r <= 1'b0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
      busy_r      <= 1'b0;
`ifdef FPU_SEQ_TIMEOUT_EN
      wait_cnt_r  <= '0;
      err_r       <= 1'b0;
`endif
    end else begin
      fpu_start_r <= 1'b0;
      case (state_r)
        ST_LOAD: begin
          if (in_accept_s) begin
            // Bytes 0-3 fill op_a, bytes 4-7 fill op_b, least significant byte first.
            if (!byte_cnt_r[2]) begin
              op_a_r[{byte_cnt_r[1:0], 3'b000} +: 8] <= bus.in_byte;
            end else begin
              op_b_r[{byte_cnt_r[1:0], 3'b000} +: 8] <= bus.in_byte;
            end
`ifdef FPU_SEQ_TIMEOUT_EN
            if (byte_cnt_r == 3'd0) begin
              err_r <= 1'b0;
            end
`endif
            byte_cnt_r <= byte_cnt_r + 3'd1;
            busy_r     <= 1'b1;
            if (byte_cnt_r == 3'd7) begin
              state_r     <= ST_START;
              fpu_start_r <= 1'b1;
              in_ready_r  <= 1'b0;
            end
          end
        end
        ST_START: begin
          state_r <= ST_WAIT;
`ifdef FPU_SEQ_TIMEOUT_EN
          wait_cnt_r <= '0;
`endif
        end
        ST_WAIT: begin
          if (bus.fpu_done) begin
            result_r    <= bus.fpu_result;
            out_byte_r  <= bus.fpu_result[7:0];
            out_valid_r <= 1'b1;
            send_cnt_r  <= 2'd0;
            state_r     <= ST_SEND;
          end
`ifdef FPU_SEQ_TIMEOUT_EN
          // A result arriving on the final allowed cycle still wins over the timeout.
          else if (timeout_s) begin
            result_r    <= TIMEOUT_RESULT;
            out_byte_r  <= TIMEOUT_RESULT[7:0];
            out_valid_r <= 1'b1;
            send_cnt_r  <= 2'd0;
            err_r       <= 1'b1;
            state_r     <= ST_SEND;
          end else begin
            wait_cnt_r <= wait_cnt_r + WAIT_CNT_W'(1);
          end
`endif
        end
        ST_SEND: begin
          if (out_accept_s) begin
            if (send_cnt_r == 2'd3) begin
              state_r     <= ST_LOAD;
              out_valid_r <= 1'b0;
              out_byte_r  <= 8'h00;
              in_ready_r  <= 1'b1;
              busy_r      <= 1'b0;
              byte_cnt_r  <= 3'd0;
              send_cnt_r  <= 2'd0;
            end else begin
              send_cnt_r <= send_cnt_r + 2'd1;
              out_byte_r <= byte_sel(result_r, send_cnt_r + 2'd1);
            end
          end
        end
        default: begin
          state_r     <= ST_LOAD;
          byte_cnt_r  <= 3'd0;
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.op_a      = op_a_r;
  assign bus.op_b      = op_b_r;
  assign bus.fpu_start = fpu_start_r;
  assign bus.out_byte  = out_byte_r;
  assign bus.out_valid = out_valid_r;
  assign bus.busy      = busy_r;
`ifdef FPU_SEQ_TIMEOUT_EN
  assign bus.err       = err_r;
`else
  assign bus.err       = 1'b0;
`endif

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// Directed self-checking bench for fpu_op_sequencer; the timeout scenario runs only with FPU_SEQ_TIMEOUT_EN.
`timescale 1ns/1ps
module tb_fpu_op_sequencer;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  fpu_op_sequencer_if bus ();

  fpu_op_sequencer #(.TIMEOUT_CYCLES(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Feeds eight operand bytes (byte 0 in data[7:0]) with gap idle cycles before each byte.
  task automatic load_operands(input logic [63:0] data, input int gap);
    for (int i = 0; i < 8; i++) begin
      repeat (gap) begin
        @(posedge clk); #1;
      end
      checks++;
      if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL load_in_ready byte %0d: got %b expected 1", i, bus.in_ready); end
      bus.in_valid = 1'b1;
      bus.in_byte  = data[8*i +: 8];
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.in_byte  = 8'hEE;
      if (i == 0) begin
        checks++;
        if (bus.busy !== 1'b1) begin errors++; $display("FAIL load_busy: got %b expected 1", bus.busy); end
      end
    end
    checks++;
    if (bus.fpu_start !== 1'b1) begin errors++; $display("FAIL start_pulse: got %b expected 1", bus.fpu_start); end
    checks++;
    if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL start_in_ready: got %b expected 0", bus.in_ready); end
    checks++;
    if (bus.op_a !== data[31:0]) begin errors++; $display("FAIL op_a: got %h expected %h", bus.op_a, data[31:0]); end
    checks++;
    if (bus.op_b !== data[63:32]) begin errors++; $display("FAIL op_b: got %h expected %h", bus.op_b, data[63:32]); end
  endtask

  // Called in the START cycle; returns fpu_done in the cyc-th cycle after START.
  task automatic fpu_respond(input logic [31:0] res, input int cyc);
    for (int i = 0; i < cyc; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.fpu_start !== 1'b0 || bus.out_valid !== 1'b0) begin
        errors++; $display("FAIL wait_cycle %0d: start %b valid %b expected 0 0", i, bus.fpu_start, bus.out_valid);
      end
    end
    bus.fpu_done   = 1'b1;
    bus.fpu_result = res;
    @(posedge clk); #1;
    bus.fpu_done   = 1'b0;
    bus.fpu_result = 32'h0000_0000;
  endtask

  // Consumes the four result bytes, optionally stalling stall_n cycles on byte stall_k.
  task automatic drain(input logic [31:0] res, input int stall_k, input int stall_n);
    logic [7:0] exp;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp = res[8*k +: 8];
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_byte !== exp) begin
        errors++; $display("FAIL out_byte %0d: got valid %b byte %h expected 1 %h", k, bus.out_valid, bus.out_byte, exp);
      end
      if (k == stall_k) begin
        bus.out_ready = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
          @(posedge clk); #1;
          checks++;
          if (bus.out_valid !== 1'b1 || bus.out_byte !== exp) begin
            errors++; $display("FAIL out_stall %0d: got valid %b byte %h expected 1 %h", s, bus.out_valid, bus.out_byte, exp);
          end
        end
        bus.out_ready = 1'b1;
      end
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL back_to_load: got valid %b ready %b busy %b expected 0 1 0", bus.out_valid, bus.in_ready, bus.busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.fpu_start !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl: got ready %b busy %b valid %b start %b expected 1 0 0 0", bus.in_ready, bus.busy, bus.out_valid, bus.fpu_start);
    end
    checks++;
    if (bus.op_a !== 32'h0 || bus.op_b !== 32'h0 || bus.out_byte !== 8'h00 || bus.err !== 1'b0) begin
      errors++; $display("FAIL reset_data: got a %h b %h byte %h err %b expected zeros", bus.op_a, bus.op_b, bus.out_byte, bus.err);
    end
  endtask

  task automatic test_basic();
    load_operands(64'h4000_0000_3F80_0000, 0);
    fpu_respond(32'h4000_0000, 3);
    drain(32'h4000_0000, -1, 0);
    checks++;
    if (bus.err !== 1'b0) begin errors++; $display("FAIL basic_err: got %b expected 0", bus.err); end
  endtask

  task automatic test_gaps();
    load_operands(64'h4000_0000_3F80_0000, 2);
    fpu_respond(32'h4000_0000, 3);
    drain(32'h4000_0000, -1, 0);
  endtask

  task automatic test_out_stall();
    load_operands(64'h4000_0000_3F80_0000, 0);
    fpu_respond(32'h4000_0000, 3);
    drain(32'h4000_0000, 1, 5);
  endtask

  task automatic test_back_to_back();
    // 2.0 * 3.0 = 6.0 with the fastest possible FPU response.
    load_operands(64'h4040_0000_4000_0000, 0);
    fpu_respond(32'h40C0_0000, 1);
    drain(32'h40C0_0000, 3, 2);
  endtask

  task automatic test_reset_mid_wait();
    load_operands(64'h4000_0000_3F80_0000, 0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.fpu_done   = 1'b1;
    bus.fpu_result = 32'h1234_5678;
    @(posedge clk); #1;
    bus.fpu_done = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
        errors++; $display("FAIL reset_abort %0d: got valid %b ready %b busy %b expected 0 1 0", i, bus.out_valid, bus.in_ready, bus.busy);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (bus.op_a !== 32'h0) begin errors++; $display("FAIL reset_abort_op_a: got %h expected 0", bus.op_a); end
  endtask

  task automatic test_done_in_load();
    bus.fpu_done   = 1'b1;
    bus.fpu_result = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    bus.fpu_done = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.fpu_start !== 1'b0) begin
      errors++; $display("FAIL done_in_load: got valid %b ready %b busy %b start %b expected 0 1 0 0", bus.out_valid, bus.in_ready, bus.busy, bus.fpu_start);
    end
  endtask

`ifdef FPU_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    load_operands(64'h4000_0000_3F80_0000, 0);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL timeout_early %0d: got valid %b expected 0", i, bus.out_valid); end
    end
    @(posedge clk); #1;
    checks++;
    if (bus.err !== 1'b1) begin errors++; $display("FAIL timeout_err: got %b expected 1", bus.err); end
    drain(32'h7FC0_0000, -1, 0);
    checks++;
    if (bus.err !== 1'b1) begin errors++; $display("FAIL timeout_err_sticky: got %b expected 1", bus.err); end
    bus.in_valid = 1'b1;
    bus.in_byte  = 8'h11;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    checks++;
    if (bus.err !== 1'b0) begin errors++; $display("FAIL timeout_err_clear: got %b expected 0", bus.err); end
  endtask
`endif

  initial begin
    checks         = 0;
    errors         = 0;
    rst_n          = 1'b0;
    bus.in_byte    = 8'h00;
    bus.in_valid   = 1'b0;
    bus.fpu_done   = 1'b0;
    bus.fpu_result = 32'h0000_0000;
    bus.out_ready  = 1'b0;
    test_reset();
    test_done_in_load();
    test_basic();
    test_gaps();
    test_out_stall();
    test_back_to_back();
    test_reset_mid_wait();
`ifdef FPU_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fpu_op_sequencer.md
FPU_OP_SEQUENCER -- requirements
Module: fpu_op_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64, meaning the maximum number of WAIT cycles before abort (used only with the timeout feature).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port in_byte  input  8  operand byte stream.
REQ-005 SHALL have port in_valid  input  1  in_byte valid.
REQ-006 SHALL have port in_ready  output  1  sequencer accepts in_byte.
REQ-007 SHALL have port op_a  output  32  FPU operand A.
REQ-008 SHALL have port op_b  output  32  FPU operand B.
REQ-009 SHALL have port fpu_start  output  1  one-cycle launch pulse to the FPU multiplier.
REQ-010 SHALL have port fpu_done  input  1  FPU result valid (single-cycle pulse).
REQ-011 SHALL have port fpu_result  input  32  FPU result, valid when fpu_done=1.
REQ-012 SHALL have port out_byte  output  8  result byte stream.
REQ-013 SHALL have port out_valid  output  1  out_byte valid.
REQ-014 SHALL have port out_ready  input  1  consumer accepts out_byte.
REQ-015 SHALL have port busy  output  1  high in every state except LOAD with byte count 0.
REQ-016 SHALL have port err  output  1  sticky timeout flag.

Function
REQ-017 SHALL implement states LOAD, START, WAIT, SEND; transitions only on the rising edge of clk.
REQ-018 LOAD: in_ready=1; byte accepted when in_valid&&in_ready; 3-bit count 0..7; bytes 0-3 -> op_a[7:0]..[31:24], bytes 4-7 -> op_b[7:0]..[31:24] (little-endian).
REQ-019 in_valid gaps in LOAD SHALL stall the count with no loss or duplication.
REQ-020 Acceptance of byte 7 SHALL move to START on the same edge; START SHALL drive fpu_start=1 for exactly one cycle, then move to WAIT.
REQ-021 op_a/op_b SHALL hold stable from START until the next LOAD byte 0 is accepted.
REQ-022 WAIT: on fpu_done=1, fpu_result SHALL be captured into a 32-bit result register and the state SHALL move to SEND; fpu_done in any other state SHALL be ignored.
REQ-023 SEND: out_valid=1, out_byte = result byte[k], k=0..3, LSB first; k advances on out_valid&&out_ready; out_byte SHALL hold while out_ready=0.
REQ-024 Acceptance of byte 3 in SEND SHALL return to LOAD with count 0 on the same edge; in_ready SHALL be 0 in START, WAIT and SEND.
REQ-025 Minimum latency: fpu_start high 1 cycle after byte-7 acceptance; first out_valid 1 cycle after the fpu_done cycle.
REQ-026 err SHALL clear on acceptance of LOAD byte 0 and otherwise hold its value.

Reset
REQ-027 While rst_n=0 at a clock edge: state=LOAD, all counts 0, op_a=op_b=0, result=0, fpu_start=0, out_valid=0, out_byte=0, err=0, in_ready=1 from the following cycle.
REQ-028 Reset asserted in any state, including mid-WAIT or mid-SEND, SHALL abort the operation; a later fpu_done SHALL be ignored.

Configuration
REQ-029 With macro FPU_SEQ_TIMEOUT_EN defined, a WAIT cycle counter SHALL be implemented; after TIMEOUT_CYCLES WAIT cycles without fpu_done, result SHALL be 32'h7FC00000, err SHALL be set to 1, and the state SHALL move to SEND.
REQ-030 Without FPU_SEQ_TIMEOUT_EN, WAIT SHALL persist indefinitely, err SHALL be tied to 0 and no timeout counter SHALL exist.

Verification
REQ-031 Bytes 00 00 80 3F 00 00 00 40, model returns 0x40000000 3 cycles after start -> op_a=3F800000, op_b=40000000, one fpu_start pulse, out bytes 00 00 00 40.
REQ-032 in_valid deasserted 2 cycles between each byte -> same op_a/op_b as REQ-031, no extra bytes consumed.
REQ-033 out_ready low for 5 cycles on byte 1 -> out_byte stays 0x00 (byte 1 of 0x40000000) for those cycles, with out_valid=1 throughout.
REQ-034 rst_n low for 1 cycle mid-WAIT, then fpu_done pulse -> out_valid stays 0, in_ready=1, busy=0.
REQ-035 FPU_SEQ_TIMEOUT_EN defined, TIMEOUT_CYCLES=8, no fpu_done -> after 8 WAIT cycles, err=1 and out bytes 00 00 C0 7F; err clears on the next byte 0 accepted.
REQ-036 fpu_done pulsed during LOAD -> ignored; no state change and no out_valid.
